// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the controller state enum, opcode and funct constants, the 5-bit
// ALUControl codes (shared with the alu block), the ALU-op selector used by
// the ALU decoder, and the alusrcb / pcsrc mux encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder.
// Ports:
//   aluop_i         add / sub / use-funct selector from the controller
//   funct_i         instr[5:0]
//   alu_ctrl_o      5-bit ALUControl for the alu block
//   funct_illegal_o high when aluop_i selects funct and funct is unsupported
module mips_alu_decoder
    import mips_pkg::*;
(
    input  aluop_e      aluop_i,
    input  logic [5:0]  funct_i,
    output logic [4:0]  alu_ctrl_o,
    output logic        funct_illegal_o
);

    always_comb begin
        alu_ctrl_o      = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM plus ALU decoder.
// Optional feature macro: MIPS_MC_CTRL_BNE_EN (adds bne via the BRANCH state).
//
// state    | meaning
// ---------+------------------------------------------------------
// FETCH    | read instr at PC, load IR, PC <= PC + 4
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | ALUOut <= A + signext imm (lw/sw address)
// MEMRD    | read data memory at ALUOut
// MEMWB    | rt <= MDR
// MEMWR    | write data memory at ALUOut
// EXECUTE  | R-type ALU op selected by funct
// ALUWB    | rd <= ALUOut (suppressed after an unknown funct)
// BRANCH   | compare A-B, PC <= ALUOut when taken
// ADDIEX   | ALUOut <= A + signext imm
// ADDIWB   | rt <= ALUOut
// JUMP     | PC <= jump target
//
// Ports: clk, reset (sync, active-high), op/funct from IR, zero from alu;
// datapath selects iord, regdst, memtoreg, alusrca, alusrcb, pcsrc; write
// enables memwrite, irwrite, regwrite, pcen; ALUControl; illegal_op pulse.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6,
    parameter int ACW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    output logic           iord,
    output logic           memwrite,
    output logic           irwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic           pcen,
    output logic [ACW-1:0] ALUControl,
    output logic           illegal_op
);

    state_e     state_q, state_d, state_eff;
    logic       bad_funct_q, bad_funct_d;
    aluop_e     aluop;
    logic [4:0] alu_ctrl;
    logic       funct_illegal;
`ifdef MIPS_MC_CTRL_BNE_EN
    logic       is_bne_q, is_bne_d;
`endif

    mips_alu_decoder u_alu_dec (
        .aluop_i         (aluop),
        .funct_i         (funct),
        .alu_ctrl_o      (alu_ctrl),
        .funct_illegal_o (funct_illegal)
    );

    assign ALUControl = ACW'(alu_ctrl);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            bad_funct_q <= 1'b0;
`ifdef MIPS_MC_CTRL_BNE_EN
            is_bne_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bad_funct_q <= bad_funct_d;
`ifdef MIPS_MC_CTRL_BNE_EN
            is_bne_q    <= is_bne_d;
`endif
        end
    end

    // While reset is high, decode as FETCH so every select shows its FETCH
    // value; the write enables are then forced low below.
    always_comb begin
        state_eff   = reset ? S_FETCH : state_q;
        state_d     = S_FETCH;
        bad_funct_d = bad_funct_q;
`ifdef MIPS_MC_CTRL_BNE_EN
        is_bne_d    = is_bne_q;
`endif
        aluop       = ALUOP_ADD;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_B;
        pcsrc       = PCSRC_ALU;
        pcen        = 1'b0;
        illegal_op  = 1'b0;

        case (state_eff)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = SRCB_FOUR;
                pcen    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
`ifdef MIPS_MC_CTRL_BNE_EN
                is_bne_d = (op == OP_BNE);
`endif
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                // IR is held across the instruction, so op is still valid here.
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_FUNCT;
                illegal_op  = funct_illegal;
                bad_funct_d = funct_illegal;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = ~bad_funct_q;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
`ifdef MIPS_MC_CTRL_BNE_EN
                pcen    = is_bne_q ? ~zero : zero;
`else
                pcen    = zero;
`endif
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = PCSRC_JUMP;
                pcen  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            pcen       = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multicycle MIPS control unit. Moore FSM plus ALU decoder, directly upstream of the alu block.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the datapath muxes and write enables, and generates the 5-bit ALUControl consumed by alu.
- Samples alu's zero flag for branch resolution.

Parameters:
- OPW, 6, opcode field width.
- FNW, 6, funct field width.
- ACW, 5, ALUControl width; must match the alu block.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  OPW  instr[31:26] from the instruction register.
- funct  input  FNW  instr[5:0] from the instruction register.
- zero  input  1  alu zero flag.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  output  1  data memory write enable.
- irwrite  output  1  instruction register load.
- regdst  output  1  destination register: 0=rt, 1=rd.
- memtoreg  output  1  writeback source: 0=ALUOut, 1=MDR.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A operand: 0=PC, 1=A register.
- alusrcb  output  2  ALU B operand: 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
- pcsrc  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- pcen  output  1  PC write enable.
- ALUControl  output  ACW  operation code to alu.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode or funct.

Behaviour:
- State register updates at posedge clk. While reset=1 the next state is FETCH.
- All outputs are Moore-decoded from state, except pcen, ALUControl in EXECUTE, and illegal_op.
- In every cycle reset=1, all write enables (memwrite, irwrite, regwrite, pcen) are forced to 0. Other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it; no partial write occurs in that cycle.
- States and transitions:
  - FETCH -> DECODE. iord=0, irwrite=1, alusrca=0, alusrcb=01, ALUControl=ADD, pcsrc=00, pcen=1.
  - DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next state by op:
    - lw(0x23) or sw(0x2B) -> MEMADR
    - R-type(0x00) -> EXECUTE
    - beq(0x04) -> BRANCH
    - addi(0x08) -> ADDIEX
    - j(0x02) -> JUMP
    - anything else -> FETCH, with illegal_op=1 for that cycle.
  - MEMADR: alusrca=1, alusrcb=10, ADD. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1 -> MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR: iord=1, memwrite=1 -> FETCH.
  - EXECUTE: alusrca=1, alusrcb=00. ALUControl from funct -> ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, ADD -> ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP: pcsrc=10, pcen=1 -> FETCH.
- ALUControl encodings:
  - ADD=5'b00010, SUB=5'b00110, AND=5'b00000, OR=5'b00001, SLT=5'b00111.
  - funct mapping: 0x20->ADD, 0x22->SUB, 0x24->AND, 0x25->OR, 0x2A->SLT.
  - Unknown funct in EXECUTE: ALUControl=ADD, illegal_op=1, and regwrite is suppressed in the following ALUWB.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Unused outputs in a state are 0; ALUControl is ADD when not otherwise specified.

Optional Feature:
- Macro: MIPS_MC_CTRL_BNE_EN.
- Defined: opcode 0x05 (bne) in DECODE -> BRANCH. In BRANCH, pcen = ~zero for bne and zero for beq. The decoded opcode is latched in DECODE for use in BRANCH.
- Undefined: 0x05 is illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Shared package mips_pkg holds:
  - state enum
  - opcode and funct constants
  - ALUControl constants (also used by the alu block)
  - alusrcb and pcsrc encodings
- Sub-module mips_alu_decoder: combinational aluop(2b: add/sub/funct) + funct -> ALUControl and funct_illegal.

Test Plan:
- reset=1 for 2 cycles during a sw in MEMWR -> memwrite=0 in those cycles; after release, state FETCH with irwrite=1, pcen=1.
- op=0x23 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 only in cycle 5.
- op=0x00, funct=0x20 -> ALUControl=5'b00010 in EXECUTE; funct=0x2A -> 5'b00111; regdst=1 and regwrite=1 in cycle 4.
- op=0x04: with zero=1 in BRANCH -> pcen=1, pcsrc=01; with zero=0 -> pcen=0; both return to FETCH.
- op=0x3F -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no register or memory write.
- With MIPS_MC_CTRL_BNE_EN: op=0x05, zero=0 -> pcen=1; zero=1 -> pcen=0.
